inst_mem_ctrl: RTL and testbench
================================

# inst_mem_ctrl

Instruction-side memory controller sitting directly upstream of `inst_fetch`. It turns the fetch stage's level-style read request (`inst_mem_read_en` + address) into a req/gnt/rvalid transaction on the instruction bus. It holds the last response in a one-entry tagged buffer and presents `inst_data`/`inst_mem_ready` back to fetch. It also handles misaligned addresses, bus errors, bus timeouts and `fence.i` flushes.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles in WAIT before a timeout fault; range 1..65535.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_mem_read_en`  in  1  fetch requests the instruction at `inst_addr`.
- `inst_addr`  in  `MAX_BIT_POS+1`  fetch address (fetch `cur_inst_addr`).
- `ifetch_flush`  in  1  invalidate the buffer and drop any in-flight response (`fence.i`, trap entry).
- `inst_data`  out  `MAX_BIT_POS+1`  instruction word; 0 when `inst_mem_ready`=0.
- `inst_mem_ready`  out  1  `inst_data` is valid for the current `inst_addr`.
- `inst_access_fault`  out  1  the response for the current `inst_addr` is a fault; qualifies `inst_mem_ready`.
- `ibus_req`  out  1  bus request.
- `ibus_addr`  out  `MAX_BIT_POS+1`  bus address, word aligned.
- `ibus_gnt`  in  1  bus accepted the request this cycle.
- `ibus_rvalid`  in  1  read data valid.
- `ibus_rdata`  in  `MAX_BIT_POS+1`  read data.
- `ibus_err`  in  1  bus error, qualified by `ibus_rvalid`.

## Operation
- Response buffer registers:
  - `buf_valid`, `buf_addr`, `buf_data`, `buf_err`.
  - `hit` = `buf_valid && buf_addr == inst_addr`, combinational.
- Combinational outputs:
  - `inst_mem_ready` = `hit`.
  - `inst_data` = `hit && !buf_err ? buf_data : 0`.
  - `inst_access_fault` = `hit && buf_err`.
- Because `hit` is combinational, an address change from fetch (sequential step or jump) drops ready in the same cycle. No stale instruction is ever presented.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Misaligned request (`inst_mem_read_en && !hit && inst_addr[1:0]!=0`): write buffer {`inst_addr`, 0, err=1}; no bus access; stay in IDLE.
  - Aligned request (`inst_mem_read_en && !hit`): latch `req_addr` = `inst_addr`; go to REQ.
- REQ:
  - `ibus_req`=1 and `ibus_addr`=`req_addr`, both held stable until `ibus_gnt`. No redirect or cancel before grant.
  - On `ibus_gnt`: go to WAIT; clear the timeout counter.
- WAIT:
  - On `ibus_rvalid`: write buffer {`req_addr`, `ibus_rdata`, `ibus_err`}, unless the drop flag is set; clear drop; go to IDLE.
  - Counter reaches `TIMEOUT_CYCLES` without rvalid: write buffer {`req_addr`, 0, err=1}; go to IDLE. A late rvalid arriving in IDLE is ignored.
- Stale responses: if `inst_addr` changes while in REQ/WAIT, the transaction still completes and the buffer is written with `req_addr`. That entry then misses, and IDLE issues the new address on the next cycle.
- `ifetch_flush`:
  - Clears `buf_valid` next edge.
  - In REQ or WAIT, sets drop, so the eventual response is not buffered.
  - Flush in the same cycle as `ibus_rvalid`: flush wins, data discarded.
- `inst_mem_read_en`=0 with a buffer hit: the buffer holds and ready stays high. Fetch may stall arbitrarily long.
- Addresses compare at full width; no wrap handling needed beyond natural `MAX_BIT_POS+1` arithmetic.

## Timing
- Reset (async, `rst`=0):
  - State IDLE; `buf_valid`=0, `buf_addr`=0, `buf_data`=0, `buf_err`=0; drop=0; counter=0.
  - Outputs: `ibus_req`=0, `ibus_addr`=0, `inst_mem_ready`=0, `inst_data`=0, `inst_access_fault`=0.
- Reset mid-transaction abandons it. The bus must tolerate a withdrawn request.
- Miss latency with immediate gnt and rvalid one cycle after gnt: read_en sampled at edge 0 → REQ at edge 1 → WAIT at edge 2 → buffer written at edge 3. `inst_mem_ready` is high from edge 3: 3 cycles.
- Misaligned fault: ready+fault from edge 1.
- Hit: 0 cycles (combinational).
- One outstanding transaction maximum. `ibus_req` is never asserted in WAIT.
- Timeout: fault visible `TIMEOUT_CYCLES`+1 edges after the grant edge.

## Structure
- Width and boot macros (`MAX_BIT_POS`, `BOOT_ADDR`) come from `config.v`. Add there:
  - `IBUS_TIMEOUT_DEFAULT`.
  - The state encodings `IMC_IDLE`=2'd0, `IMC_REQ`=2'd1, `IMC_WAIT`=2'd2.
- Single module. The timeout counter is small enough to stay inline; no sub-module.

## Test plan
- Cold miss:
  - Stimulus: read_en=1, addr=0x0000_0000; gnt immediate; rvalid one cycle later with rdata=0x0000_0013.
  - Response: ready high 3 cycles after request, inst_data=0x13; a repeated read of the same address hits with no `ibus_req`.
- Jump during WAIT:
  - Stimulus: addr 0x100 granted, then addr changes to 0x200 before rvalid.
  - Response: ready stays 0; buffer tagged 0x100; next `ibus_addr`=0x200; ready with 0x200's data.
- Gnt backpressure:
  - Stimulus: gnt held low for 5 cycles.
  - Response: `ibus_req`/`ibus_addr`=0x40 stable all 5 cycles; exactly one transaction.
- Bus error and misaligned address:
  - Stimulus 1: rvalid with `ibus_err`=1 → response: ready=1, fault=1, inst_data=0.
  - Stimulus 2: addr=0x102 → response: fault at the next edge, `ibus_req` never asserted.
- Timeout (TIMEOUT_CYCLES=4):
  - Stimulus: no rvalid after grant.
  - Response: fault 5 edges after the grant edge; a late rvalid is ignored.
- Flush with simultaneous rvalid:
  - Stimulus: `ifetch_flush` and `ibus_rvalid` in the same cycle.
  - Response: buffer invalid and ready=0; a re-request issues a new bus transaction.
- Async reset while in WAIT:
  - Stimulus: assert `rst` low during WAIT.
  - Response: all outputs 0 immediately.

Source files
------------

// File: rtl/inst_mem_ctrl_pkg.sv
// Shared types and constants for the instruction-side memory controller.
package inst_mem_ctrl_pkg;

    localparam int MAX_BIT_POS          = 31;
    localparam int IBUS_TIMEOUT_DEFAULT = 255;

    typedef logic [MAX_BIT_POS:0] word_t;

    typedef enum logic [1:0] {
        IMC_IDLE = 2'd0,
        IMC_REQ  = 2'd1,
        IMC_WAIT = 2'd2
    } imc_state_e;

    // An instruction address is usable on the bus only when word aligned.
    function automatic logic is_misaligned(input word_t addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Instruction bus: req/gnt request phase followed by an rvalid response phase.
interface inst_mem_ctrl_if;

    logic                       req;
    inst_mem_ctrl_pkg::word_t   addr;
    logic                       gnt;
    logic                       rvalid;
    inst_mem_ctrl_pkg::word_t   rdata;
    logic                       err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: turns fetch's level read request into one
// bus transaction at a time and keeps the last response in a tagged buffer.
module inst_mem_ctrl
    import inst_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = IBUS_TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_mem_read_en,
    input  word_t                   inst_addr,
    input  logic                    ifetch_flush,
    output word_t                   inst_data,
    output logic                    inst_mem_ready,
    output logic                    inst_access_fault,
    inst_mem_ctrl_if.master         ibus
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    imc_state_e  state_q, state_d;
    word_t       req_addr_q, req_addr_d;
    logic        buf_valid_q, buf_valid_d;
    word_t       buf_addr_q, buf_addr_d;
    word_t       buf_data_q, buf_data_d;
    logic        buf_err_q, buf_err_d;
    logic        drop_q, drop_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hit_s;

    // Buffer lookup and fetch-facing outputs; an address change drops ready at once.
    always_comb begin
        hit_s             = buf_valid_q && (buf_addr_q == inst_addr);
        inst_mem_ready    = hit_s;
        inst_access_fault = hit_s && buf_err_q;
        if (hit_s && !buf_err_q) begin
            inst_data = buf_data_q;
        end else begin
            inst_data = '0;
        end
    end

    // Bus request is driven straight from state and the latched address.
    always_comb begin
        ibus.req  = (state_q == IMC_REQ);
        ibus.addr = req_addr_q;
    end

    // Next-state, buffer update, drop flag and timeout counter.
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_err_d   = buf_err_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;

        case (state_q)
            IMC_IDLE: begin
                if (inst_mem_read_en && !hit_s) begin
                    if (is_misaligned(inst_addr)) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = inst_addr;
                        buf_data_d  = '0;
                        buf_err_d   = 1'b1;
                    end else begin
                        req_addr_d = inst_addr;
                        state_d    = IMC_REQ;
                    end
                end else begin
                    state_d = IMC_IDLE;
                end
            end
            IMC_REQ: begin
                if (ibus.gnt) begin
                    state_d = IMC_WAIT;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = IMC_REQ;
                end
            end
            IMC_WAIT: begin
                if (ibus.rvalid) begin
                    if (!drop_q && !ifetch_flush) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = req_addr_q;
                        buf_data_d  = ibus.rdata;
                        buf_err_d   = ibus.err;
                    end else begin
                        buf_valid_d = buf_valid_q;
                    end
                    drop_d  = 1'b0;
                    state_d = IMC_IDLE;
                end else if (cnt_q >= TIMEOUT_LIM) begin
                    if (!drop_q && !ifetch_flush) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = req_addr_q;
                        buf_data_d  = '0;
                        buf_err_d   = 1'b1;
                    end else begin
                        buf_valid_d = buf_valid_q;
                    end
                    drop_d  = 1'b0;
                    state_d = IMC_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IMC_IDLE;
                drop_d  = 1'b0;
            end
        endcase

        // Flush invalidates the buffer and poisons an unfinished transaction.
        if (ifetch_flush) begin
            buf_valid_d = 1'b0;
            if ((state_q != IMC_IDLE) && (state_d != IMC_IDLE)) begin
                drop_d = 1'b1;
            end else begin
                drop_d = drop_d;
            end
        end else begin
            buf_valid_d = buf_valid_d;
        end
    end

    // State and buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IMC_IDLE;
            req_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_err_q   <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_err_q   <= buf_err_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed self-checking bench for inst_mem_ctrl (TIMEOUT_CYCLES = 4).
module tb_inst_mem_ctrl;
    import inst_mem_ctrl_pkg::*;

    logic  clk;
    logic  rst;
    logic  read_en;
    word_t addr;
    logic  flush;
    word_t data;
    logic  ready;
    logic  fault;
    int    n_cmp;
    int    n_bad;

    inst_mem_ctrl_if bus ();

    inst_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .inst_mem_read_en  (read_en),
        .inst_addr         (addr),
        .ifetch_flush      (flush),
        .inst_data         (data),
        .inst_mem_ready    (ready),
        .inst_access_fault (fault),
        .ibus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; read_en = 1'b0; addr = '0; flush = 1'b0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
        tick(); tick();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%0h exp=0", ready); end
        n_cmp++; if (data !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%0h exp=0", data); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got=%0h exp=0", fault); end
        n_cmp++; if (bus.req !== 1'b0 || bus.addr !== 32'h0) begin n_bad++; $display("FAIL reset_bus req=%0h addr=%0h exp=0/0", bus.req, bus.addr); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        read_en = 1'b1; addr = 32'h0000_0000; bus.gnt = 1'b1;
        tick();
        n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'h0 || ready !== 1'b0) begin n_bad++; $display("FAIL cold_req req=%0h addr=%0h ready=%0h exp=1/0/0", bus.req, bus.addr, ready); end
        tick();
        n_cmp++; if (bus.req !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL cold_wait req=%0h ready=%0h exp=0/0", bus.req, ready); end
        bus.rvalid = 1'b1; bus.rdata = 32'h0000_0013;
        tick();
        bus.rvalid = 1'b0; bus.rdata = '0;
        n_cmp++; if (ready !== 1'b1 || data !== 32'h13 || fault !== 1'b0) begin n_bad++; $display("FAIL cold_ready ready=%0h data=%0h fault=%0h exp=1/13/0", ready, data, fault); end
        tick();
        n_cmp++; if (bus.req !== 1'b0 || ready !== 1'b1 || data !== 32'h13) begin n_bad++; $display("FAIL cold_hit req=%0h ready=%0h data=%0h exp=0/1/13", bus.req, ready, data); end
        read_en = 1'b0;
        tick(); tick();
        n_cmp++; if (ready !== 1'b1 || data !== 32'h13 || bus.req !== 1'b0) begin n_bad++; $display("FAIL stall_hold ready=%0h data=%0h req=%0h exp=1/13/0", ready, data, bus.req); end
    endtask

    task automatic test_jump_wait();
        read_en = 1'b1; addr = 32'h100; bus.gnt = 1'b1;
        tick();
        n_cmp++; if (bus.addr !== 32'h100 || bus.req !== 1'b1) begin n_bad++; $display("FAIL jump_req1 addr=%0h req=%0h exp=100/1", bus.addr, bus.req); end
        tick();
        addr = 32'h200;
        bus.rvalid = 1'b1; bus.rdata = 32'hAAAA_0100;
        tick();
        bus.rvalid = 1'b0;
        n_cmp++; if (ready !== 1'b0 || data !== 32'h0) begin n_bad++; $display("FAIL jump_stale ready=%0h data=%0h exp=0/0", ready, data); end
        addr = 32'h100; #1;
        n_cmp++; if (ready !== 1'b1 || data !== 32'hAAAA_0100) begin n_bad++; $display("FAIL jump_tag ready=%0h data=%0h exp=1/aaaa0100", ready, data); end
        addr = 32'h200; #1;
        tick();
        n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'h200) begin n_bad++; $display("FAIL jump_req2 req=%0h addr=%0h exp=1/200", bus.req, bus.addr); end
        tick();
        bus.rvalid = 1'b1; bus.rdata = 32'hBBBB_0200;
        tick();
        bus.rvalid = 1'b0;
        n_cmp++; if (ready !== 1'b1 || data !== 32'hBBBB_0200) begin n_bad++; $display("FAIL jump_done ready=%0h data=%0h exp=1/bbbb0200", ready, data); end
    endtask

    task automatic test_backpressure();
        int accepts;
        accepts = 0;
        bus.gnt = 1'b0; addr = 32'h40; read_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'h40) begin n_bad++; $display("FAIL bp_hold cyc=%0d req=%0h addr=%0h exp=1/40", i, bus.req, bus.addr); end
            tick();
        end
        bus.gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.req === 1'b1 && bus.gnt === 1'b1) accepts++;
            if (i == 1) begin bus.rvalid = 1'b1; bus.rdata = 32'h0000_4040; end
            else begin bus.rvalid = 1'b0; end
            tick();
        end
        bus.rvalid = 1'b0;
        n_cmp++; if (accepts !== 1) begin n_bad++; $display("FAIL bp_count got=%0d exp=1", accepts); end
        n_cmp++; if (ready !== 1'b1 || data !== 32'h4040) begin n_bad++; $display("FAIL bp_data ready=%0h data=%0h exp=1/4040", ready, data); end
    endtask

    task automatic test_error_misaligned();
        addr = 32'h80; bus.gnt = 1'b1; read_en = 1'b1;
        tick(); tick();
        bus.rvalid = 1'b1; bus.err = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        tick();
        bus.rvalid = 1'b0; bus.err = 1'b0;
        n_cmp++; if (ready !== 1'b1 || fault !== 1'b1 || data !== 32'h0) begin n_bad++; $display("FAIL buserr ready=%0h fault=%0h data=%0h exp=1/1/0", ready, fault, data); end
        addr = 32'h102; #1;
        n_cmp++; if (ready !== 1'b0 || bus.req !== 1'b0) begin n_bad++; $display("FAIL mis_pre ready=%0h req=%0h exp=0/0", ready, bus.req); end
        tick();
        n_cmp++; if (ready !== 1'b1 || fault !== 1'b1 || data !== 32'h0 || bus.req !== 1'b0) begin n_bad++; $display("FAIL mis_fault ready=%0h fault=%0h data=%0h req=%0h exp=1/1/0/0", ready, fault, data, bus.req); end
        tick();
        n_cmp++; if (bus.req !== 1'b0 || fault !== 1'b1) begin n_bad++; $display("FAIL mis_noreq req=%0h fault=%0h exp=0/1", bus.req, fault); end
    endtask

    task automatic test_timeout();
        addr = 32'h300; bus.gnt = 1'b1; read_en = 1'b1;
        tick();
        tick();
        bus.gnt = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (ready !== 1'b0 || bus.req !== 1'b0) begin n_bad++; $display("FAIL to_early edge=%0d ready=%0h req=%0h exp=0/0", i, ready, bus.req); end
        end
        tick();
        n_cmp++; if (ready !== 1'b1 || fault !== 1'b1 || data !== 32'h0) begin n_bad++; $display("FAIL to_fault ready=%0h fault=%0h data=%0h exp=1/1/0", ready, fault, data); end
        bus.rvalid = 1'b1; bus.rdata = 32'h0000_1234;
        tick();
        bus.rvalid = 1'b0;
        n_cmp++; if (fault !== 1'b1 || data !== 32'h0 || bus.req !== 1'b0) begin n_bad++; $display("FAIL to_late fault=%0h data=%0h req=%0h exp=1/0/0", fault, data, bus.req); end
    endtask

    task automatic test_flush_rvalid();
        addr = 32'h500; bus.gnt = 1'b1; read_en = 1'b1;
        tick(); tick();
        bus.rvalid = 1'b1; bus.rdata = 32'h55; flush = 1'b1;
        tick();
        bus.rvalid = 1'b0; flush = 1'b0;
        n_cmp++; if (ready !== 1'b0 || data !== 32'h0) begin n_bad++; $display("FAIL flush_drop ready=%0h data=%0h exp=0/0", ready, data); end
        tick();
        n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'h500) begin n_bad++; $display("FAIL flush_rereq req=%0h addr=%0h exp=1/500", bus.req, bus.addr); end
        tick();
        bus.rvalid = 1'b1; bus.rdata = 32'h66;
        tick();
        bus.rvalid = 1'b0;
        n_cmp++; if (ready !== 1'b1 || data !== 32'h66) begin n_bad++; $display("FAIL flush_refill ready=%0h data=%0h exp=1/66", ready, data); end
    endtask

    task automatic test_async_reset();
        addr = 32'h600; bus.gnt = 1'b1; read_en = 1'b1;
        tick(); tick();
        n_cmp++; if (bus.addr !== 32'h600) begin n_bad++; $display("FAIL ar_pre addr=%0h exp=600", bus.addr); end
        addr = 32'h500;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b0 || data !== 32'h0 || fault !== 1'b0 || bus.req !== 1'b0 || bus.addr !== 32'h0) begin n_bad++; $display("FAIL ar_outputs ready=%0h data=%0h fault=%0h req=%0h addr=%0h exp=0", ready, data, fault, bus.req, bus.addr); end
        read_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.req !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL ar_idle req=%0h ready=%0h exp=0/0", bus.req, ready); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_cold_miss();
        test_jump_wait();
        test_backpressure();
        test_error_misaligned();
        test_timeout();
        test_flush_rvalid();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
